id_wb_scoreboard: RTL and testbench

- Hazard and write-back controller for the integer register file.
- Keeps a per-register outstanding-write counter and gates instruction issue on RAW hazards and counter saturation.
- Arbitrates the single register-file write port between two write-back requesters: port 0 is the ALU, port 1 is the LSU.
- Sits between decode/issue and the register file. Drives the register file's reg_write/data_write and replaces the file's internal modified tracking.

---
 rtl/id_wb_scoreboard_pkg.sv | 12 +
 rtl/id_wb_scoreboard_wb_rr_arbiter.sv | 40 ++++
 rtl/id_wb_scoreboard.sv | 122 ++++++++++++
 tb/tb_id_wb_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_wb_scoreboard_pkg.sv
// Shared widths and write-back port indices for the register scoreboard.
// No logic, no latency; constants only.
package id_wb_scoreboard_pkg;

  localparam int REG_NUM        = 5;
  localparam int COMMON_WIDTH   = 32;
  localparam int MAX_MODI_WIDTH = 2;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;

endpackage

// File: rtl/id_wb_scoreboard_wb_rr_arbiter.sv
// Two-requester round-robin arbiter; grant is combinational (0 cycles).
// Never stalls a lone requester; the priority pointer flips only on a contested grant.
module wb_rr_arbiter
  import id_wb_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // prio_q names the requester that wins the next contested cycle.
  logic prio_q;
  logic prio_d;
  logic contested;

  assign contested = req_i[WB_ALU] & req_i[WB_LSU];

  always_comb begin
    gnt_o         = '0;
    gnt_o[WB_ALU] = req_i[WB_ALU] & (~req_i[WB_LSU] | (prio_q == 1'(WB_ALU)));
    gnt_o[WB_LSU] = req_i[WB_LSU] & (~req_i[WB_ALU] | (prio_q == 1'(WB_LSU)));
  end

  always_comb begin
    prio_d = prio_q;
    if (contested) begin
      prio_d = ~prio_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'(WB_ALU);
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/id_wb_scoreboard.sv
// Register-file hazard scoreboard and write-back arbiter: issue gating is combinational,
// write-back reaches the register file 1 cycle after grant; issue backpressures on RAW/saturation.
module id_wb_scoreboard
  import id_wb_scoreboard_pkg::*;
#(
  parameter int REG_CNT = 32,
  parameter int CNT_W   = MAX_MODI_WIDTH,
  parameter int DATA_W  = COMMON_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  input  logic [REG_NUM-1:0] iss_rs1,
  input  logic [REG_NUM-1:0] iss_rs2,
  input  logic [REG_NUM-1:0] iss_rd,
  output logic               iss_ready,
  output logic               busy_rs1,
  output logic               busy_rs2,
  input  logic               wb0_valid,
  input  logic [REG_NUM-1:0] wb0_rd,
  input  logic [DATA_W-1:0]  wb0_data,
  output logic               wb0_ready,
  input  logic               wb1_valid,
  input  logic [REG_NUM-1:0] wb1_rd,
  input  logic [DATA_W-1:0]  wb1_data,
  output logic               wb1_ready,
  output logic               rf_we,
  output logic [REG_NUM-1:0] rf_reg_write,
  output logic [DATA_W-1:0]  rf_data_write,
  output logic               err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt_q [REG_CNT];
  logic [CNT_W-1:0]   cnt_d [REG_CNT];
  logic [REG_CNT-1:0] inc_vec;
  logic [REG_CNT-1:0] dec_vec;

  logic               rf_we_q, rf_we_d;
  logic [REG_NUM-1:0] rf_reg_write_q, rf_reg_write_d;
  logic [DATA_W-1:0]  rf_data_write_q, rf_data_write_d;
  logic               err_underflow_q, err_underflow_d;

  logic               rd_full;
  logic               iss_fire;
  logic [1:0]         gnt;
  logic [REG_NUM-1:0] wb_rd_sel;
  logic [DATA_W-1:0]  wb_data_sel;

  // Registered counters only: a write retiring this cycle does not clear busy yet.
  assign busy_rs1  = (iss_rs1 != '0) && (cnt_q[iss_rs1] != '0);
  assign busy_rs2  = (iss_rs2 != '0) && (cnt_q[iss_rs2] != '0);
  assign rd_full   = (iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX);
  assign iss_ready = iss_valid & ~busy_rs1 & ~busy_rs2 & ~rd_full;
  assign iss_fire  = iss_valid & iss_ready;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({wb1_valid, wb0_valid}),
    .gnt_o (gnt)
  );

  assign wb0_ready = gnt[WB_ALU];
  assign wb1_ready = gnt[WB_LSU];

  assign wb_rd_sel   = gnt[WB_LSU] ? wb1_rd   : wb0_rd;
  assign wb_data_sel = gnt[WB_LSU] ? wb1_data : wb0_data;

  // A granted write to x0 is consumed here and never reaches the file or the counters.
  always_comb begin
    rf_we_d         = (|gnt) && (wb_rd_sel != '0);
    rf_reg_write_d  = rf_we_d ? wb_rd_sel   : '0;
    rf_data_write_d = rf_we_d ? wb_data_sel : '0;
  end

  always_comb begin
    err_underflow_d = err_underflow_q;
    inc_vec         = '0;
    dec_vec         = '0;
    for (int r = 0; r < REG_CNT; r++) begin
      cnt_d[r]   = cnt_q[r];
      inc_vec[r] = (r != 0) && iss_fire && (iss_rd == REG_NUM'(r));
      dec_vec[r] = (r != 0) && rf_we_q && (rf_reg_write_q == REG_NUM'(r));
      if (dec_vec[r] && (cnt_q[r] == '0)) begin
        err_underflow_d = 1'b1;
      end
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_CNT; r++) begin
        cnt_q[r] <= '0;
      end
      rf_we_q         <= 1'b0;
      rf_reg_write_q  <= '0;
      rf_data_write_q <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_CNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      rf_we_q         <= rf_we_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_data_write_q <= rf_data_write_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_reg_write  = rf_reg_write_q;
  assign rf_data_write = rf_data_write_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_id_wb_scoreboard.sv
// Directed bench for id_wb_scoreboard: expected register-file writes are queued
// when a grant is checked and compared by a negedge monitor when rf_we appears.
module tb_id_wb_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_ready, busy_rs1, busy_rs2;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        rf_we;
  logic [4:0]  rf_reg_write;
  logic [31:0] rf_data_write;
  logic        err_underflow;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  id_wb_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .iss_valid     (iss_valid),
    .iss_rs1       (iss_rs1),
    .iss_rs2       (iss_rs2),
    .iss_rd        (iss_rd),
    .iss_ready     (iss_ready),
    .busy_rs1      (busy_rs1),
    .busy_rs2      (busy_rs2),
    .wb0_valid     (wb0_valid),
    .wb0_rd        (wb0_rd),
    .wb0_data      (wb0_data),
    .wb0_ready     (wb0_ready),
    .wb1_valid     (wb1_valid),
    .wb1_rd        (wb1_rd),
    .wb1_data      (wb1_data),
    .wb1_ready     (wb1_ready),
    .rf_we         (rf_we),
    .rf_reg_write  (rf_reg_write),
    .rf_data_write (rf_data_write),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge of the grant cycle; the write lands one cycle later.
  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rf_reg_write=%0d data=0x%0h at cycle %0d, none expected",
                 rf_reg_write, rf_data_write, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_reg", 32'(rf_reg_write), 32'(mon_e.rd));
        chk("wr_data", rf_data_write, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    iss_valid = 1'b1;
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_reg_write", rf_reg_write, 0);
    chk("rst_rf_data_write", rf_data_write, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_wb0_ready", wb0_ready, 0);
    step();
    rst = 1'b1;
    iss_valid = 1'b0;

    // RAW stall on x5
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    chk("raw_issue_rd5", iss_ready, 1);
    step();
    iss_rd = 5'd0; iss_rs1 = 5'd5;
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("raw_stall_ready", iss_ready, 0);
    chk("raw_busy_rs1", busy_rs1, 1);
    chk("raw_busy_rs2", busy_rs2, 0);
    chk("raw_wb0_grant", wb0_ready, 1);
    chk("raw_wb1_nogrant", wb1_ready, 0);
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    wb0_valid = 1'b0;
    @(negedge clk);
    chk("raw_no_bypass", iss_ready, 0);
    step();
    @(negedge clk);
    chk("raw_release_ready", iss_ready, 1);
    chk("raw_release_busy", busy_rs1, 0);
    step();
    iss_valid = 1'b0; iss_rs1 = 5'd0;

    // Saturation of x7 at 3 outstanding writes
    iss_valid = 1'b1; iss_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sat_issue", iss_ready, 1);
      step();
    end
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h0000_0777;
    @(negedge clk);
    chk("sat_blocked", iss_ready, 0);
    chk("sat_wb1_grant", wb1_ready, 1);
    expect_wr(5'd7, 32'h0000_0777);
    step();
    wb1_valid = 1'b0;
    @(negedge clk);
    chk("sat_blocked_retiring", iss_ready, 0);
    step();
    @(negedge clk);
    chk("sat_accept_after_retire", iss_ready, 1);
    step();
    iss_valid = 1'b0; iss_rd = 5'd0;

    // Outstanding writes for the contention phase: x3 twice, x4 once
    iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk); chk("prime_x3_a", iss_ready, 1); step();
    @(negedge clk); chk("prime_x3_b", iss_ready, 1); step();
    iss_rd = 5'd4;
    @(negedge clk); chk("prime_x4", iss_ready, 1); step();
    iss_valid = 1'b0; iss_rd = 5'd0;

    // Contention: alternating grants wb0, wb1, wb0
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h3333_0000;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h4444_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cont_wb0_ready", wb0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_wb1_ready", wb1_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) expect_wr(5'd3, 32'h3333_0000);
      else            expect_wr(5'd4, 32'h4444_0000);
      step();
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clk);
    chk("cont_no_underflow", err_underflow, 0);
    step();

    // Simultaneous inc/dec on x9
    iss_valid = 1'b1; iss_rd = 5'd9;
    @(negedge clk); chk("sim_issue_first", iss_ready, 1);
    step();
    iss_valid = 1'b0; iss_rd = 5'd0;
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0000_9999;
    @(negedge clk);
    chk("sim_wb0_grant", wb0_ready, 1);
    expect_wr(5'd9, 32'h0000_9999);
    step();
    wb0_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    @(negedge clk);
    chk("sim_issue_while_retire", iss_ready, 1);
    step();
    iss_rd = 5'd0; iss_rs1 = 5'd9;
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h9999_0001;
    @(negedge clk);
    chk("sim_busy_persists", busy_rs1, 1);
    chk("sim_stall", iss_ready, 0);
    chk("sim_wb0_grant2", wb0_ready, 1);
    expect_wr(5'd9, 32'h9999_0001);
    step();
    wb0_valid = 1'b0;
    @(negedge clk);
    chk("sim_busy_retiring", busy_rs1, 1);
    step();
    @(negedge clk);
    chk("sim_busy_cleared", busy_rs1, 0);
    chk("sim_ready_after", iss_ready, 1);
    step();
    iss_valid = 1'b0; iss_rs1 = 5'd0;

    // Write-back to x0 is granted but never reaches the file
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h0000_0BAD;
    @(negedge clk);
    chk("x0_wb1_grant", wb1_ready, 1);
    step();
    wb1_valid = 1'b0;
    @(negedge clk);
    chk("x0_no_we", rf_we, 0);
    chk("x0_addr_idle", rf_reg_write, 0);
    step();

    // Underflow: retire x12 with no outstanding write
    wb0_valid = 1'b1; wb0_rd = 5'd12; wb0_data = 32'h0000_C0C0;
    @(negedge clk);
    chk("uf_wb0_grant", wb0_ready, 1);
    expect_wr(5'd12, 32'h0000_C0C0);
    step();
    wb0_valid = 1'b0;
    @(negedge clk);
    chk("uf_not_yet", err_underflow, 0);
    step();
    @(negedge clk);
    chk("uf_set", err_underflow, 1);
    repeat (3) step();
    @(negedge clk);
    chk("uf_sticky", err_underflow, 1);
    step();

    // Reset mid-traffic: granted write must be discarded
    wb0_valid = 1'b1; wb0_rd = 5'd13; wb0_data = 32'h1313_1313;
    @(negedge clk);
    chk("mid_wb0_grant", wb0_ready, 1);
    #1;
    rst = 1'b0;
    wb0_valid = 1'b0;
    iss_valid = 1'b1; iss_rs1 = 5'd7;
    #1;
    chk("mid_rst_err_clear", err_underflow, 0);
    chk("mid_rst_x7_cleared", busy_rs1, 0);
    chk("mid_rst_iss_ready", iss_ready, 1);
    step();
    @(negedge clk);
    chk("mid_rst_no_we", rf_we, 0);
    chk("mid_rst_addr", rf_reg_write, 0);
    chk("mid_rst_data", rf_data_write, 0);
    step();
    rst = 1'b1;
    iss_valid = 1'b0; iss_rs1 = 5'd0;
    @(negedge clk);
    chk("post_rst_no_we", rf_we, 0);
    chk("post_rst_err", err_underflow, 0);
    step();
    step();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
